// File: rtl/avl_burst_master.sv
// Avalon-MM burst master: 4/8-beat write bursts fed from a local write-data FIFO, and 4/8-beat read bursts.
// Optional read-data watchdog enabled by defining AVL_BM_TIMEOUT_EN.
//
// state    | meaning
// IDLE     | accepting commands; a legal write may be parked here (pend_q) until the FIFO holds cmd_len words
// WR_BURST | issuing write beats from the FIFO head
// RD_REQ   | read request asserted until the slave drops waitrequest
// RD_DATA  | collecting readdatavalid beats
module avl_burst_master #(
  parameter int AVL_A_W     = 22,
  parameter int AVL_D_W     = 16,
  parameter int AVL_BE_W    = 2,
  parameter int WFIFO_DEPTH = 8
) (
  input  logic                csi_clockreset_clk,
  input  logic                csi_clockreset_reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_wr,
  input  logic [AVL_A_W-1:0]  cmd_addr,
  input  logic [3:0]          cmd_len,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [AVL_D_W-1:0]  wr_data,
  output logic                rd_valid,
  output logic [AVL_D_W-1:0]  rd_data,
  output logic [AVL_A_W-1:0]  avm_address,
  output logic                avm_read,
  output logic                avm_write,
  output logic                avm_beginbursttransfer,
  output logic [3:0]          avm_burstcount,
  output logic [AVL_D_W-1:0]  avm_writedata,
  output logic [AVL_BE_W-1:0] avm_byteenable,
  input  logic                avm_waitrequest,
  input  logic                avm_readdatavalid,
  input  logic [AVL_D_W-1:0]  avm_readdata,
  output logic                busy,
  output logic                err_len,
  output logic                rd_timeout
);

  localparam int PW = $clog2(WFIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_REQ, RD_DATA} state_t;

  state_t               state_q;
  logic                 pend_q;
  logic [3:0]           beats_q;
  logic [AVL_A_W-1:0]   avm_address_q;
  logic [3:0]           avm_burstcount_q;
  logic                 avm_write_q;
  logic                 avm_read_q;
  logic                 avm_begin_q;
  logic                 err_len_q;
  logic                 rd_valid_q;
  logic [AVL_D_W-1:0]   rd_data_q;

  logic [AVL_D_W-1:0]   mem_q [WFIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q;
  logic [PW-1:0]        rd_ptr_q;
  logic [CW-1:0]        count_q;
  logic [CW-1:0]        count_d;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 len_ok;
  logic                 fifo_has_cmd;
  logic                 fifo_has_pend;

  assign full          = (count_q == CW'(WFIFO_DEPTH));
  assign push          = wr_valid && !full;
  assign pop           = (state_q == WR_BURST) && !avm_waitrequest;
  assign len_ok        = (cmd_len == 4'd4) || (cmd_len == 4'd8);
  assign fifo_has_cmd  = (count_q >= CW'(cmd_len));
  assign fifo_has_pend = (count_q >= CW'(avm_burstcount_q));

  assign wr_ready               = !full;
  assign cmd_ready              = (state_q == IDLE) && !pend_q;
  assign busy                   = (state_q != IDLE);
  assign avm_address            = avm_address_q;
  assign avm_burstcount         = avm_burstcount_q;
  assign avm_write              = avm_write_q;
  assign avm_read               = avm_read_q;
  assign avm_beginbursttransfer = avm_begin_q;
  assign avm_byteenable         = '1;
  assign avm_writedata          = (state_q == WR_BURST) ? mem_q[rd_ptr_q] : '0;
  assign err_len                = err_len_q;
  assign rd_valid               = rd_valid_q;
  assign rd_data                = rd_data_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + CW'(1);
    else if (pop && !push)
      count_d = count_q - CW'(1);
  end

  always_ff @(posedge csi_clockreset_clk) begin
    if (push)
      mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge csi_clockreset_clk or posedge csi_clockreset_reset) begin
    if (csi_clockreset_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push)
        wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)
        rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

`ifdef AVL_BM_TIMEOUT_EN
  // Terminal count at zero puts the pulse 255 idle cycles after the last beat.
  localparam logic [7:0] WD_RELOAD = 8'd254;
  logic [7:0] wd_q;
  logic       rd_timeout_q;
  assign rd_timeout = rd_timeout_q;
`else
  assign rd_timeout = 1'b0;
`endif

  always_ff @(posedge csi_clockreset_clk or posedge csi_clockreset_reset) begin
    if (csi_clockreset_reset) begin
      state_q          <= IDLE;
      pend_q           <= 1'b0;
      beats_q          <= '0;
      avm_address_q    <= '0;
      avm_burstcount_q <= '0;
      avm_write_q      <= 1'b0;
      avm_read_q       <= 1'b0;
      avm_begin_q      <= 1'b0;
      err_len_q        <= 1'b0;
      rd_valid_q       <= 1'b0;
      rd_data_q        <= '0;
`ifdef AVL_BM_TIMEOUT_EN
      wd_q             <= '0;
      rd_timeout_q     <= 1'b0;
`endif
    end else begin
      err_len_q  <= 1'b0;
      rd_valid_q <= 1'b0;
`ifdef AVL_BM_TIMEOUT_EN
      rd_timeout_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (pend_q) begin
            if (fifo_has_pend) begin
              state_q     <= WR_BURST;
              pend_q      <= 1'b0;
              avm_write_q <= 1'b1;
              avm_begin_q <= 1'b1;
              beats_q     <= avm_burstcount_q;
            end
          end else if (cmd_valid) begin
            if (!len_ok) begin
              err_len_q <= 1'b1;
            end else begin
              avm_address_q    <= cmd_addr;
              avm_burstcount_q <= cmd_len;
              beats_q          <= cmd_len;
              if (!cmd_wr) begin
                state_q     <= RD_REQ;
                avm_read_q  <= 1'b1;
                avm_begin_q <= 1'b1;
              end else if (fifo_has_cmd) begin
                state_q     <= WR_BURST;
                avm_write_q <= 1'b1;
                avm_begin_q <= 1'b1;
              end else begin
                pend_q <= 1'b1;
              end
            end
          end
        end

        WR_BURST: begin
          avm_begin_q <= 1'b0;
          if (!avm_waitrequest) begin
            if (beats_q == 4'd1) begin
              state_q          <= IDLE;
              avm_write_q      <= 1'b0;
              avm_address_q    <= '0;
              avm_burstcount_q <= '0;
            end
            beats_q <= beats_q - 4'd1;
          end
        end

        RD_REQ: begin
          avm_begin_q <= 1'b0;
          if (!avm_waitrequest) begin
            state_q    <= RD_DATA;
            avm_read_q <= 1'b0;
`ifdef AVL_BM_TIMEOUT_EN
            wd_q       <= WD_RELOAD;
`endif
          end
        end

        RD_DATA: begin
          if (avm_readdatavalid) begin
            rd_data_q  <= avm_readdata;
            rd_valid_q <= 1'b1;
            beats_q    <= beats_q - 4'd1;
`ifdef AVL_BM_TIMEOUT_EN
            wd_q       <= WD_RELOAD;
`endif
            if (beats_q == 4'd1) begin
              state_q          <= IDLE;
              avm_address_q    <= '0;
              avm_burstcount_q <= '0;
            end
          end
`ifdef AVL_BM_TIMEOUT_EN
          else if (wd_q == 8'd0) begin
            rd_timeout_q     <= 1'b1;
            state_q          <= IDLE;
            avm_address_q    <= '0;
            avm_burstcount_q <= '0;
          end else begin
            wd_q <= wd_q - 8'd1;
          end
`endif
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avl_burst_master.sv
// Self-checking bench for avl_burst_master: a cycle vector table plus directed multi-cycle sequences.
// Covers the AVL_BM_TIMEOUT_EN watchdog when that macro is defined, and its absence otherwise.
module tb_avl_burst_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [21:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic        wr_valid, wr_ready;
  logic [15:0] wr_data;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic [21:0] avm_address;
  logic        avm_read, avm_write, avm_beginbursttransfer;
  logic [3:0]  avm_burstcount;
  logic [15:0] avm_writedata;
  logic [1:0]  avm_byteenable;
  logic        avm_waitrequest, avm_readdatavalid;
  logic [15:0] avm_readdata;
  logic        busy, err_len, rd_timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  avl_burst_master dut (
    .csi_clockreset_clk    (clk),
    .csi_clockreset_reset  (rst),
    .cmd_valid             (cmd_valid),
    .cmd_ready             (cmd_ready),
    .cmd_wr                (cmd_wr),
    .cmd_addr              (cmd_addr),
    .cmd_len               (cmd_len),
    .wr_valid              (wr_valid),
    .wr_ready              (wr_ready),
    .wr_data               (wr_data),
    .rd_valid              (rd_valid),
    .rd_data               (rd_data),
    .avm_address           (avm_address),
    .avm_read              (avm_read),
    .avm_write             (avm_write),
    .avm_beginbursttransfer(avm_beginbursttransfer),
    .avm_burstcount        (avm_burstcount),
    .avm_writedata         (avm_writedata),
    .avm_byteenable        (avm_byteenable),
    .avm_waitrequest       (avm_waitrequest),
    .avm_readdatavalid     (avm_readdatavalid),
    .avm_readdata          (avm_readdata),
    .busy                  (busy),
    .err_len               (err_len),
    .rd_timeout            (rd_timeout)
  );

  typedef struct packed {
    logic        wv;
    logic [15:0] wd;
    logic        cv;
    logic        cw;
    logic [21:0] ca;
    logic [3:0]  cl;
    logic        wt;
    logic        rdv;
    logic [15:0] rdat;
    logic        e_wr;
    logic        e_rd;
    logic        e_bg;
    logic [15:0] e_wd;
    logic [3:0]  e_bc;
    logic [21:0] e_ad;
    logic        e_cr;
    logic        e_busy;
    logic        e_err;
    logic        e_rv;
    logic [15:0] e_rdat;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic wv, input logic [15:0] wd, input logic cv, input logic cw,
                     input logic [21:0] ca, input logic [3:0] cl, input logic wt, input logic rdv,
                     input logic [15:0] rdat, input logic e_wr, input logic e_rd, input logic e_bg,
                     input logic [15:0] e_wd, input logic [3:0] e_bc, input logic [21:0] e_ad,
                     input logic e_cr, input logic e_busy, input logic e_err, input logic e_rv,
                     input logic [15:0] e_rdat);
    vec_t v;
    v = '{wv, wd, cv, cw, ca, cl, wt, rdv, rdat,
          e_wr, e_rd, e_bg, e_wd, e_bc, e_ad, e_cr, e_busy, e_err, e_rv, e_rdat};
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cmd_valid = 0; cmd_wr = 0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 0; wr_data = '0;
    avm_waitrequest = 0; avm_readdatavalid = 0; avm_readdata = '0;
  endtask

  task automatic push_word(input logic [15:0] d);
    wr_valid = 1; wr_data = d;
    tick();
    wr_valid = 0;
  endtask

  task automatic send_cmd(input logic wr, input logic [21:0] a, input logic [3:0] l);
    cmd_valid = 1; cmd_wr = wr; cmd_addr = a; cmd_len = l;
    tick();
    cmd_valid = 0;
  endtask

  task automatic rd_beat(input logic [15:0] d);
    avm_readdatavalid = 1; avm_readdata = d;
    tick();
    avm_readdatavalid = 0;
  endtask

  // Expects data base, base+1, ...; stalls stall_cyc cycles on beat index stall_beat.
  task automatic write_burst(input string tag, input logic [15:0] base, input int n,
                             input int stall_beat, input int stall_cyc, input logic [21:0] a);
    int w = 0;
    int b = 0;
    int st = 0;
    int cyc = 0;
    logic first = 1'b1;
    while (!avm_write && w < 20) begin tick(); w++; end
    chk({tag, "_start"}, avm_write, 1'b1);
    while (b < n && cyc < 100) begin
      chk($sformatf("%s_b%0d", tag, b),
          {avm_write, avm_beginbursttransfer, avm_writedata, avm_burstcount, avm_address, busy},
          {1'b1, first, base + 16'(b), 4'(n), a, 1'b1});
      if (b == stall_beat && st < stall_cyc) begin
        avm_waitrequest = 1; st++;
      end else begin
        avm_waitrequest = 0; b++;
      end
      first = 1'b0;
      tick();
      cyc++;
    end
    avm_waitrequest = 0;
    chk({tag, "_beats"}, 128'(b), 128'(n));
    chk({tag, "_end"}, {avm_write, busy, cmd_ready}, 3'b001);
  endtask

  initial begin
    int n;
    logic seen;
    idle_inputs();
    rst = 1;

    add(0,0,1,1,'h10,5,0,0,0,      0,0,0,0,0,0,    1,0,1,0,0);
    add(0,0,0,0,0,0,0,0,0,         0,0,0,0,0,0,    1,0,0,0,0);
    add(1,4,0,0,0,0,0,0,0,         0,0,0,0,0,0,    1,0,0,0,0);
    add(1,5,0,0,0,0,0,0,0,         0,0,0,0,0,0,    1,0,0,0,0);
    add(1,7,0,0,0,0,0,0,0,         0,0,0,0,0,0,    1,0,0,0,0);
    add(1,9,0,0,0,0,0,0,0,         0,0,0,0,0,0,    1,0,0,0,0);
    add(0,0,1,1,'h48,4,0,0,0,      1,0,1,4,4,'h48, 0,1,0,0,0);
    add(0,0,0,0,0,0,0,0,0,         1,0,0,5,4,'h48, 0,1,0,0,0);
    add(0,0,0,0,0,0,0,0,0,         1,0,0,7,4,'h48, 0,1,0,0,0);
    add(0,0,0,0,0,0,0,0,0,         1,0,0,9,4,'h48, 0,1,0,0,0);
    add(0,0,0,0,0,0,0,0,0,         0,0,0,0,0,0,    1,0,0,0,0);
    add(0,0,1,0,'h48,8,0,0,0,      0,1,1,0,8,'h48, 0,1,0,0,0);
    add(0,0,0,0,0,0,1,1,'h55,      0,1,0,0,8,'h48, 0,1,0,0,0);
    add(0,0,0,0,0,0,0,0,0,         0,0,0,0,8,'h48, 0,1,0,0,0);
    add(0,0,0,0,0,0,0,1,1,         0,0,0,0,8,'h48, 0,1,0,1,1);
    add(0,0,0,0,0,0,0,1,3,         0,0,0,0,8,'h48, 0,1,0,1,3);
    add(0,0,0,0,0,0,0,0,0,         0,0,0,0,8,'h48, 0,1,0,0,3);
    add(0,0,0,0,0,0,0,1,1,         0,0,0,0,8,'h48, 0,1,0,1,1);
    add(0,0,0,0,0,0,0,1,7,         0,0,0,0,8,'h48, 0,1,0,1,7);
    add(0,0,0,0,0,0,0,0,0,         0,0,0,0,8,'h48, 0,1,0,0,7);
    add(0,0,0,0,0,0,0,0,0,         0,0,0,0,8,'h48, 0,1,0,0,7);
    add(0,0,0,0,0,0,0,1,6,         0,0,0,0,8,'h48, 0,1,0,1,6);
    add(0,0,0,0,0,0,0,1,2,         0,0,0,0,8,'h48, 0,1,0,1,2);
    add(0,0,0,0,0,0,0,1,0,         0,0,0,0,8,'h48, 0,1,0,1,0);
    add(0,0,0,0,0,0,0,1,8,         0,0,0,0,0,0,    1,0,0,1,8);
    add(0,0,0,0,0,0,0,1,'hAA,      0,0,0,0,0,0,    1,0,0,0,8);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctrl", {avm_write, avm_read, avm_beginbursttransfer, avm_writedata, avm_burstcount, avm_address}, '0);
    chk("rst_status", {busy, err_len, rd_valid, rd_data, rd_timeout}, '0);
    chk("rst_ready", {cmd_ready, wr_ready}, 2'b11);
    chk("byteenable", avm_byteenable, 2'b11);
    @(negedge clk) rst = 0;
    tick();

    foreach (tbl[i]) begin
      wr_valid = tbl[i].wv; wr_data = tbl[i].wd;
      cmd_valid = tbl[i].cv; cmd_wr = tbl[i].cw; cmd_addr = tbl[i].ca; cmd_len = tbl[i].cl;
      avm_waitrequest = tbl[i].wt; avm_readdatavalid = tbl[i].rdv; avm_readdata = tbl[i].rdat;
      tick();
      chk($sformatf("vec%0d", i),
          {avm_write, avm_read, avm_beginbursttransfer, avm_writedata, avm_burstcount, avm_address,
           cmd_ready, busy, err_len, rd_valid, rd_data},
          {tbl[i].e_wr, tbl[i].e_rd, tbl[i].e_bg, tbl[i].e_wd, tbl[i].e_bc, tbl[i].e_ad,
           tbl[i].e_cr, tbl[i].e_busy, tbl[i].e_err, tbl[i].e_rv, tbl[i].e_rdat});
    end
    idle_inputs();

    // len 8 write with a 3-cycle stall on beat 2
    for (int i = 0; i < 7; i++) push_word(16'hA0 + 16'(i));
    chk("fifo_7_ready", wr_ready, 1'b1);
    push_word(16'hA7);
    chk("fifo_full", wr_ready, 1'b0);
    send_cmd(1, 22'h100, 8);
    write_burst("wr8stall", 16'hA0, 8, 1, 3, 22'h100);

    // len 8 write parked until the FIFO reaches 8 words
    for (int i = 0; i < 6; i++) push_word(16'hB0 + 16'(i));
    chk("fifo_6_ready", wr_ready, 1'b1);
    send_cmd(1, 22'h200, 8);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("pend%0d", i), {avm_write, cmd_ready, busy}, 3'b000);
      tick();
    end
    push_word(16'hB6);
    push_word(16'hB7);
    chk("pend_full", {wr_ready, avm_write}, 2'b00);
    write_burst("wrpend", 16'hB0, 8, -1, 0, 22'h200);

    // reset in the middle of a write burst
    for (int i = 0; i < 4; i++) push_word(16'hC0 + 16'(i));
    send_cmd(1, 22'h300, 4);
    avm_waitrequest = 1;
    tick();
    #2 rst = 1;
    #1;
    chk("midrst_ctrl", {avm_write, avm_beginbursttransfer, avm_writedata, avm_burstcount, avm_address, busy}, '0);
    chk("midrst_ready", {wr_ready, cmd_ready}, 2'b11);
    @(negedge clk) rst = 0;
    avm_waitrequest = 0;
    seen = 0;
    repeat (6) begin tick(); if (avm_write || busy) seen = 1; end
    chk("postrst_quiet", seen, 1'b0);
    for (int i = 0; i < 4; i++) push_word(16'hD0 + 16'(i));
    send_cmd(1, 22'h304, 4);
    write_burst("postrst", 16'hD0, 4, -1, 0, 22'h304);

    // read len 4 with only 2 beats returned
    send_cmd(0, 22'h400, 4);
    tick();
    chk("rd4_data_state", {avm_read, busy}, 2'b01);
    rd_beat(16'h11);
    rd_beat(16'h22);
    chk("rd4_beat2", {rd_valid, rd_data}, {1'b1, 16'h22});
`ifdef AVL_BM_TIMEOUT_EN
    n = 0;
    while (!rd_timeout && n < 400) begin tick(); n++; end
    chk("to_delay", 128'(n), 128'd255);
    chk("to_idle", {busy, cmd_ready}, 2'b01);
    tick();
    chk("to_pulse", rd_timeout, 1'b0);
`else
    seen = 0;
    repeat (300) begin tick(); if (rd_timeout) seen = 1; end
    chk("no_timeout", seen, 1'b0);
    chk("still_busy", busy, 1'b1);
    rd_beat(16'h33);
    rd_beat(16'h44);
    chk("rd4_done", {busy, rd_valid, rd_data}, {1'b0, 1'b1, 16'h44});
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
